// File: rtl/icache_responder.sv
// Direct-mapped instruction cache for the fetch stage.
// One-cycle hits from IDLE; a miss refills the whole line from backing memory
// in ascending word order, then responds with the requested word.
module icache_responder #(
  parameter int unsigned AW    = 32,
  parameter int unsigned LINES = 64,
  parameter int unsigned WORDS = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          instrreq,
  input  logic [AW-1:0] instradr,
  output logic [31:0]   instrF,
  output logic          hit,
  output logic          abort,
  input  logic          flush,
  output logic          memreq,
  output logic [AW-1:0] memadr,
  input  logic [31:0]   memrdata,
  input  logic          memvalid
);

  localparam int unsigned OFFW = $clog2(WORDS);
  localparam int unsigned IDXW = $clog2(LINES);
  localparam int unsigned TAGW = AW - 2 - OFFW - IDXW;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REFILL  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t state, state_n;

  // Storage: tag/data arrays are not reset, only the valid bits are
  logic [TAGW-1:0]  tags  [LINES];
  logic [31:0]      data  [LINES*WORDS];
  logic [LINES-1:0] valid;

  // Latched miss request and refill progress
  logic [TAGW-1:0] ltag;
  logic [IDXW-1:0] lidx;
  logic [OFFW-1:0] loff;
  logic [OFFW-1:0] cnt;
  logic            pend_flush;

  // Incoming address fields
  logic [OFFW-1:0] off;
  logic [IDXW-1:0] idx;
  logic [TAGW-1:0] tag;
  logic            unused_adr;

  assign off        = instradr[OFFW+1:2];
  assign idx        = instradr[OFFW+IDXW+1:OFFW+2];
  assign tag        = instradr[AW-1:OFFW+IDXW+2];
  assign unused_adr = ^instradr[1:0];

  logic        lookup_hit;
  logic        miss_go;
  logic        last_beat;
  logic [31:0] resp_word;

  // Lookup and refill control decode; a same-cycle flush forces a miss
  always_comb begin
    lookup_hit = 1'b0;
    miss_go    = 1'b0;
    last_beat  = 1'b0;
    resp_word  = data[{lidx, loff}];
    if (state == IDLE && instrreq) begin
      lookup_hit = !flush && valid[idx] && (tags[idx] == tag);
      miss_go    = !lookup_hit;
    end
    if (state == REFILL && memvalid && cnt == OFFW'(WORDS-1)) begin
      last_beat = 1'b1;
    end
    // The requested word may be the one arriving on this very beat
    if (loff == cnt) begin
      resp_word = memrdata;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (miss_go) state_n = REFILL;
      REFILL:  if (last_beat) state_n = RESPOND;
      RESPOND: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Registered outputs, refill counter and latched request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit    <= 1'b0;
      abort  <= 1'b0;
      memreq <= 1'b0;
      memadr <= '0;
      instrF <= '0;
      cnt    <= '0;
      ltag   <= '0;
      lidx   <= '0;
      loff   <= '0;
    end else begin
      hit <= 1'b0;
      if (lookup_hit) begin
        hit    <= 1'b1;
        instrF <= data[{idx, off}];
      end
      if (miss_go) begin
        abort  <= 1'b1;
        memreq <= 1'b1;
        memadr <= {instradr[AW-1:OFFW+2], {(OFFW+2){1'b0}}};
        cnt    <= '0;
        ltag   <= tag;
        lidx   <= idx;
        loff   <= off;
      end
      if (state == REFILL && memvalid) begin
        cnt    <= cnt + 1'b1;
        memadr <= memadr + AW'(4);
      end
      if (last_beat) begin
        memreq <= 1'b0;
        abort  <= 1'b0;
        hit    <= 1'b1;
        instrF <= resp_word;
      end
    end
  end

  // Valid bits; a flush seen during refill is deferred to refill completion
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid      <= '0;
      pend_flush <= 1'b0;
    end else if (state == REFILL) begin
      if (flush) pend_flush <= 1'b1;
      if (last_beat) begin
        pend_flush <= 1'b0;
        if (pend_flush || flush) valid <= '0;
        else                     valid[lidx] <= 1'b1;
      end
    end else if (flush) begin
      valid <= '0;
    end
  end

  // Array writes during refill
  always_ff @(posedge clk) begin
    if (state == REFILL && memvalid) begin
      data[{lidx, cnt}] <= memrdata;
      if (last_beat) tags[lidx] <= ltag;
    end
  end

endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder with a 2-cycle-latency memory model.
module tb_icache_responder;

  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          instrreq = 1'b0;
  logic [AW-1:0] instradr = '0;
  logic [31:0]   instrF;
  logic          hit;
  logic          abort;
  logic          flush = 1'b0;
  logic          memreq;
  logic [AW-1:0] memadr;
  logic [31:0]   memrdata = '0;
  logic          memvalid = 1'b0;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [AW-1:0] addr_log [$];

  icache_responder #(.AW(32), .LINES(64), .WORDS(4)) dut (
    .clk      (clk),
    .reset    (rst_n),
    .instrreq (instrreq),
    .instradr (instradr),
    .instrF   (instrF),
    .hit      (hit),
    .abort    (abort),
    .flush    (flush),
    .memreq   (memreq),
    .memadr   (memadr),
    .memrdata (memrdata),
    .memvalid (memvalid)
  );

  always #5 clk = ~clk;

  // Backing memory contents
  function automatic logic [31:0] memword(input logic [AW-1:0] a);
    if (a >= 32'h40 && a < 32'h50) return ((a - 32'h40) / 4 + 1) * 32'h11;
    return {16'hbeef, a[15:0]};
  endfunction

  task automatic check(input string tagname, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tagname, got, exp);
    end
  endtask

  // Memory model: answers a held memreq every second cycle
  initial begin
    int lat = 0;
    forever begin
      @(negedge clk);
      memvalid = 1'b0;
      if (memreq) begin
        lat++;
        if (lat == 2) begin
          memvalid = 1'b1;
          memrdata = memword(memadr);
          addr_log.push_back(memadr);
          lat = 0;
        end
      end else begin
        lat = 0;
      end
    end
  end

  // Present one request for one cycle; outputs sampled at the following negedge
  task automatic request(input logic [AW-1:0] a);
    instrreq = 1'b1;
    instradr = a;
    @(negedge clk);
    instrreq = 1'b0;
  endtask

  task automatic wait_hit(input string tagname, input logic [31:0] exp);
    bit found = 0;
    bit overlap = 0;
    for (int i = 0; i < 60; i++) begin
      if (hit && abort) overlap = 1;
      if (hit) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check({tagname, "_hit"}, 32'(found), 32'd1);
    check({tagname, "_overlap"}, 32'(overlap), 32'd0);
    if (found) begin
      check({tagname, "_data"}, instrF, exp);
      check({tagname, "_abort"}, 32'(abort), 32'd0);
    end
  endtask

  task automatic check_log(input string tagname, input logic [AW-1:0] base);
    check({tagname, "_beats"}, 32'(addr_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++)
      check({tagname, "_adr"}, addr_log[i], base + 32'(4 * i));
  endtask

  task automatic wait_log(input int n);
    for (int i = 0; i < 40 && addr_log.size() < n; i++) @(negedge clk);
    check("log_wait", 32'(addr_log.size() >= n), 32'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_hit", 32'(hit), 32'd0);
    check("rst_abort", 32'(abort), 32'd0);
    check("rst_memreq", 32'(memreq), 32'd0);
    check("rst_memadr", memadr, 32'h0);
    check("rst_instrF", instrF, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Cold miss
    addr_log.delete();
    request(32'h40);
    check("cold_abort", 32'(abort), 32'd1);
    check("cold_memreq", 32'(memreq), 32'd1);
    check("cold_memadr", memadr, 32'h40);
    check("cold_nohit", 32'(hit), 32'd0);
    wait_hit("cold", 32'h11);
    check_log("cold", 32'h40);
    @(negedge clk);
    check("cold_memreq_off", 32'(memreq), 32'd0);

    // Hit after fill
    request(32'h48);
    check("hit48", 32'(hit), 32'd1);
    check("hit48_data", instrF, 32'h33);
    check("hit48_memreq", 32'(memreq), 32'd0);
    @(negedge clk);
    check("hit_pulse", 32'(hit), 32'd0);
    check("hold_instrF", instrF, 32'h33);

    // Back-to-back hits
    instrreq = 1'b1; instradr = 32'h40;
    @(negedge clk);
    check("b2b0", 32'(hit), 32'd1);
    check("b2b0_data", instrF, 32'h11);
    instradr = 32'h44;
    @(negedge clk);
    check("b2b1", 32'(hit), 32'd1);
    check("b2b1_data", instrF, 32'h22);
    instradr = 32'h4C;
    @(negedge clk);
    instrreq = 1'b0;
    check("b2b2", 32'(hit), 32'd1);
    check("b2b2_data", instrF, 32'h44);
    @(negedge clk);

    // Conflict miss on the same index
    addr_log.delete();
    request(32'h440);
    check("conf_abort", 32'(abort), 32'd1);
    wait_hit("conf", memword(32'h440));
    check_log("conf", 32'h440);
    @(negedge clk);
    addr_log.delete();
    request(32'h40);
    check("conf_remiss", 32'(abort), 32'd1);
    wait_hit("conf_refill", 32'h11);
    @(negedge clk);

    // Flush mid-refill
    addr_log.delete();
    request(32'h88);
    wait_log(2);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_hit("flush", memword(32'h88));
    check_log("flush", 32'h80);
    @(negedge clk);
    addr_log.delete();
    request(32'h88);
    check("flush_remiss", 32'(abort), 32'd1);
    wait_hit("flush_refill", memword(32'h88));
    @(negedge clk);

    // Async reset mid-refill
    addr_log.delete();
    request(32'h104);
    wait_log(1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_memreq", 32'(memreq), 32'd0);
    check("arst_abort", 32'(abort), 32'd0);
    check("arst_hit", 32'(hit), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    addr_log.delete();
    request(32'h104);
    check("arst_remiss", 32'(abort), 32'd1);
    check("arst_memadr", memadr, 32'h100);
    wait_hit("arst", memword(32'h104));
    check_log("arst", 32'h100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Direct-mapped instruction cache that serves the fetch stage of the pipelined core.
- Answers the core's instruction requests (instradr, instrreq) with instrF, hit and abort.
- On a miss, refills a full line from backing memory one word at a time.
- Sits between the core's fetch port and the shared memory bus.

Parameters:
- AW, 32, byte-address width; instradr and memadr width.
- LINES, 64, number of cache lines; power of 2, at least 2.
- WORDS, 4, 32-bit words per line; power of 2, at least 2.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- instrreq  input  1  fetch request, sampled at posedge.
- instradr  input  AW  fetch byte address; bits [1:0] ignored.
- instrF  output  32  fetched instruction; valid only while hit=1.
- hit  output  1  one-cycle pulse: instrF carries the word for the accepted request.
- abort  output  1  high while the accepted request is being refilled.
- flush  input  1  invalidate all lines.
- memreq  output  1  word read request to backing memory, held until memvalid.
- memadr  output  AW  word-aligned read address.
- memrdata  input  32  returned word.
- memvalid  input  1  memrdata valid for the current memadr; consumes the request.

Behaviour:
- Address split:
  - offset = instradr[1+log2(WORDS):2]
  - index = next log2(LINES) bits
  - tag = remaining upper bits
- Storage: data array LINES×WORDS×32, tag array, valid bit per line. Arrays are read combinationally; writes occur at posedge.
- Reset (reset=0, async):
  - all valid bits = 0; state = IDLE.
  - hit = 0, abort = 0, memreq = 0, memadr = 0, instrF = 0, refill counter = 0, pending flush = 0.
  - Tag and data arrays are not reset.
  - Reset during REFILL abandons the refill with no line written. Backing memory must tolerate the dropped request.
- States: IDLE, REFILL, RESPOND.
- IDLE:
  - instrreq=1 and the line is valid with a matching tag: next cycle hit=1 and instrF=data[index][offset], registered. Stay in IDLE. Hit latency is 1 cycle.
  - instrreq=1 and miss: latch the request address. Next cycle abort=1, memreq=1, memadr={tag,index,0-offset,2'b00}, counter=0. Go to REFILL.
  - A new instrreq in the cycle of a hit pulse is accepted normally, so back-to-back hits are allowed.
  - flush=1 with instrreq=1 in the same cycle: flush takes effect first and the request is treated as a miss.
- REFILL:
  - abort held at 1 and memreq held at 1. instrreq is ignored; the core is stalled.
  - On each memvalid: write memrdata to data[index][counter], counter+1, memadr+4.
  - On the memvalid with counter=WORDS-1: write the tag, set valid (unless a flush is pending), deassert memreq. Next cycle go to RESPOND.
  - Words are always fetched from offset 0 upward; there is no critical-word-first.
  - flush during REFILL sets a pending flag. At completion all valid bits are cleared and the refilled line is not marked valid, but the response is still delivered from the just-written data.
- RESPOND:
  - hit=1 for one cycle; instrF = the refilled word at the latched offset; abort=0.
  - Return to IDLE.
- hit and abort are never high in the same cycle.
- instrF holds its last value when hit=0.

Test Plan:
- Cold miss: after reset, instrreq with instradr=0x0000_0040. Required:
  - abort=1 the next cycle.
  - memadr steps 0x40, 0x44, 0x48, 0x4C, with memvalid returning 0x11, 0x22, 0x33, 0x44 at 2-cycle latency.
  - RESPOND gives hit=1 and instrF=0x11; abort drops in the same cycle.
- Hit after fill: instrreq on 0x48 → hit=1 and instrF=0x33 one cycle later. memreq stays 0.
- Conflict miss: fill 0x40, then request 0x40+LINES*16=0x440 (same index, new tag). Required:
  - refill from 0x440.
  - a later request to 0x40 misses again.
- Back-to-back hits: instrreq on 0x40, 0x44, 0x4C in consecutive cycles → three consecutive hit pulses with instrF 0x11, 0x22, 0x44.
- Flush mid-refill: assert flush after the 2nd memvalid. Required:
  - the response still delivers the correct word.
  - a re-request of the same address misses.
- Async reset mid-refill: drive reset=0 between clock edges after the 1st memvalid. Required:
  - memreq, abort and hit fall immediately.
  - after release, a request to the same address misses and refills from offset 0.
